// File: rtl/seq_hw_sched.sv
// seq_hw_sched: round-robin scheduler that shares one seq_hw weighted-sum
// datapath (O = 23*I1 + 18*I2 + 13*I3) among NREQ requesters. The winner's
// operands are registered onto the datapath and held for LAT cycles. dp_o is
// then sampled into res and returned with a one-cycle done pulse.
//
// Handshake: a requester raises req[k] with stable operands and holds them
// until ack[k] pulses (operands captured). done[k] pulses exactly LAT cycles
// after ack[k], with res valid in that cycle. res then holds until the next done.
module seq_hw_sched #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int OW   = 16,
  parameter int LAT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_i1,
  input  logic [NREQ*DW-1:0] req_i2,
  input  logic [NREQ*DW-1:0] req_i3,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [OW-1:0]     res,
  output logic              busy,
  output logic [DW-1:0]     dp_i1,
  output logic [DW-1:0]     dp_i2,
  output logic [DW-1:0]     dp_i3,
  input  logic [OW-1:0]     dp_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [OW-1:0]   res_q, res_d;
  logic [DW-1:0]   dp_i1_q, dp_i1_d;
  logic [DW-1:0]   dp_i2_q, dp_i2_d;
  logic [DW-1:0]   dp_i3_q, dp_i3_d;

  logic            found;
  logic [PW-1:0]   win;
  logic            last_cycle;

  // Winner search: first asserted request scanning ptr, ptr+1, ... modulo NREQ
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign last_cycle = (cnt_q == CW'(LAT - 1));

  // State register: every piece of sequential state, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      dp_i1_q <= '0;
      dp_i2_q <= '0;
      dp_i3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      res_q   <= res_d;
      dp_i1_q <= dp_i1_d;
      dp_i2_q <= dp_i2_d;
      dp_i3_q <= dp_i3_d;
    end
  end

  // Next-state logic: grant leaves IDLE, the last held cycle returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_RUN;
      S_RUN:   if (last_cycle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath register next values: capture on grant, sample dp_o at the end
  always_comb begin
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_d   = '0;
    done_d  = '0;
    res_d   = res_q;
    dp_i1_d = dp_i1_q;
    dp_i2_d = dp_i2_q;
    dp_i3_d = dp_i3_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          dp_i1_d    = req_i1[win*DW +: DW];
          dp_i2_d    = req_i2[win*DW +: DW];
          dp_i3_d    = req_i3[win*DW +: DW];
          owner_d    = win;
          ack_d[win] = 1'b1;
          cnt_d      = '0;
          ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cycle) begin
          res_d          = dp_o;
          done_d[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign res   = res_q;
  assign busy  = (state_q == S_RUN);
  assign dp_i1 = dp_i1_q;
  assign dp_i2 = dp_i2_q;
  assign dp_i3 = dp_i3_q;

endmodule

// File: tb/tb_seq_hw_sched.sv
// Bench for seq_hw_sched with NREQ=3, LAT=4 and a behavioural seq_hw datapath.
module tb_seq_hw_sched;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int OW   = 16;
  localparam int LAT  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_i1 = '0;
  logic [NREQ*DW-1:0] req_i2 = '0;
  logic [NREQ*DW-1:0] req_i3 = '0;
  logic [NREQ-1:0]   ack, done;
  logic [OW-1:0]     res;
  logic              busy;
  logic [DW-1:0]     dp_i1, dp_i2, dp_i3;
  logic [OW-1:0]     dp_o;

  always #5 clk = ~clk;

  // seq_hw datapath
  assign dp_o = 16'(23 * int'(dp_i1) + 18 * int'(dp_i2) + 13 * int'(dp_i3));

  seq_hw_sched #(.NREQ(NREQ), .DW(DW), .OW(OW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_i1(req_i1), .req_i2(req_i2), .req_i3(req_i3),
    .ack(ack), .done(done), .res(res), .busy(busy),
    .dp_i1(dp_i1), .dp_i2(dp_i2), .dp_i3(dp_i3), .dp_o(dp_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cycles = 0;

  logic [NREQ-1:0]    exp_ack_q[$];
  logic [NREQ+OW-1:0] exp_done_q[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset === 1'b1 && busy === 1'b1) busy_cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    req_i1[k*DW +: DW] = a;
    req_i2[k*DW +: DW] = b;
    req_i3[k*DW +: DW] = c;
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack !== '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now("ack_timeout");
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_done_q.size() == 0 && exp_ack_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("quiet_timeout");
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ack !== '0) begin
        if (exp_ack_q.size() == 0) fail_now("unexpected_ack");
        else check("ack", 32'(ack), 32'(exp_ack_q.pop_front()));
      end
      if (done !== '0) begin
        if (exp_done_q.size() == 0) fail_now("unexpected_done");
        else check("done_res", 32'({done, res}), 32'(exp_done_q.pop_front()));
      end
      if (ack !== '0 && done !== '0) fail_now("ack_done_same_cycle");
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, t2, t3, b0;

    // 1: reset held with all requests high
    req = 3'b111;
    set_ops(0, 8'd1, 8'd2, 8'd3);
    set_ops(1, 8'd4, 8'd5, 8'd6);
    set_ops(2, 8'd7, 8'd8, 8'd9);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 0);
      check("rst_done", 32'(done), 0);
      check("rst_res", 32'(res), 0);
      check("rst_busy", 32'(busy), 0);
    end
    check("rst_dp_i1", 32'(dp_i1), 0);
    req = '0;
    @(posedge clk); #1 reset = 1'b1;

    // 2: single request, 255/255/255 -> 13770, busy exactly 4 cycles
    @(negedge clk);
    b0 = busy_cycles;
    set_ops(0, 8'd255, 8'd255, 8'd255);
    exp_ack_q.push_back(3'b001);
    exp_done_q.push_back({3'b001, 16'd13770});
    req = 3'b001;
    wait_ack(t0);
    req = '0;
    wait_quiet();
    check("busy_cycles", 32'(busy_cycles - b0), 4);

    // 3: round robin with all requests held (ptr=1 now, so scan starts at 1)
    //    use a fresh grant-to-2 first so ptr returns to 0
    set_ops(2, 8'd1, 8'd0, 8'd0);
    exp_ack_q.push_back(3'b100);
    exp_done_q.push_back({3'b100, 16'd23});
    req = 3'b100;
    wait_ack(t0);
    req = '0;
    wait_quiet();

    set_ops(0, 8'd10, 8'd20, 8'd30);
    set_ops(1, 8'd72, 8'd134, 8'd201);
    set_ops(2, 8'd255, 8'd255, 8'd255);
    exp_ack_q.push_back(3'b001); exp_done_q.push_back({3'b001, 16'd980});
    exp_ack_q.push_back(3'b010); exp_done_q.push_back({3'b010, 16'd6681});
    exp_ack_q.push_back(3'b100); exp_done_q.push_back({3'b100, 16'd13770});
    exp_ack_q.push_back(3'b001); exp_done_q.push_back({3'b001, 16'd980});
    req = 3'b111;
    wait_ack(t0);
    wait_ack(t1);
    wait_ack(t2);
    wait_ack(t3);
    req = '0;
    check("ack_gap_01", 32'(t1 - t0), 5);
    check("ack_gap_12", 32'(t2 - t1), 5);
    check("ack_gap_20", 32'(t3 - t2), 5);
    wait_quiet();

    // 4: priority wrap: grant to 2 leaves ptr=0, then req 0 wins over req 1
    set_ops(2, 8'd2, 8'd0, 8'd0);
    exp_ack_q.push_back(3'b100);
    exp_done_q.push_back({3'b100, 16'd46});
    req = 3'b100;
    wait_ack(t0);
    req = '0;
    wait_quiet();
    set_ops(0, 8'd0, 8'd0, 8'd1);
    set_ops(1, 8'd1, 8'd2, 8'd3);
    exp_ack_q.push_back(3'b001); exp_done_q.push_back({3'b001, 16'd13});
    exp_ack_q.push_back(3'b010); exp_done_q.push_back({3'b010, 16'd98});
    req = 3'b011;
    wait_ack(t0);
    req[0] = 1'b0;
    wait_ack(t1);
    req[1] = 1'b0;
    wait_quiet();

    // 5: operands change every cycle during RUN; datapath inputs stay put
    set_ops(1, 8'd10, 8'd20, 8'd30);
    exp_ack_q.push_back(3'b010);
    exp_done_q.push_back({3'b010, 16'd980});
    req = 3'b010;
    wait_ack(t0);
    req = '0;
    for (int i = 0; i < LAT; i++) begin
      set_ops(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      check("hold_dp_i1", 32'(dp_i1), 10);
      check("hold_dp_i2", 32'(dp_i2), 20);
      check("hold_dp_i3", 32'(dp_i3), 30);
      @(negedge clk);
    end
    wait_quiet();

    // 6: reset sampled at cnt==2 abandons the op; no done follows
    set_ops(2, 8'd1, 8'd1, 8'd1);
    exp_ack_q.push_back(3'b100);
    req = 3'b100;
    wait_ack(t0);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_res", 32'(res), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_dp_i1", 32'(dp_i1), 0);
    repeat (8) @(negedge clk);
    set_ops(1, 8'd255, 8'd255, 8'd255);
    exp_ack_q.push_back(3'b010);
    exp_done_q.push_back({3'b010, 16'd13770});
    req = 3'b110;
    wait_ack(t0);
    req = '0;
    wait_quiet();

    check("ack_q_empty", 32'(exp_ack_q.size()), 0);
    check("done_q_empty", 32'(exp_done_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

endmodule
